// File: rtl/updi_phy_pkg.sv
// Shared types and frame constants for the UPDI physical layer.
// The UART frame format is fixed by the UPDI link: start, 8 data LSB-first, even parity, 2 stops.
package updi_phy_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BREAK,
        ST_TX
    } phy_state_e;

    typedef enum logic [1:0] {
        BRK_LOW1,
        BRK_HIGH1,
        BRK_LOW2,
        BRK_HIGH2
    } brk_phase_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_BITS
    } rx_state_e;

    localparam int UART_FRAME_BITS = 12;
    localparam int UART_STOP_BITS  = 2;
    localparam int UART_DATA_BITS  = 8;
    // Receiver only samples data, parity and the first stop bit.
    localparam int UART_RX_BITS    = UART_DATA_BITS + 2;

    // Frame in transmit order: bit 0 goes on the line first.
    function automatic logic [UART_FRAME_BITS-1:0] build_frame(input logic [UART_DATA_BITS-1:0] data);
        return {{UART_STOP_BITS{1'b1}}, ^data, data, 1'b0};
    endfunction

endpackage

// File: rtl/updi_fifo.sv
// Synchronous first-word fall-through FIFO with a push that is accepted when full
// only if a pop happens on the same edge, so the occupancy never overflows.
module updi_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = rd_en && !empty;
    assign do_push = wr_en && (!full || do_pop);
    assign rd_data = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is not reset; pointers and count alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/updi_phy_core.sv
// UPDI physical layer: serialises TX FIFO bytes onto the open-drain line, deserialises
// received frames into the RX FIFO, and generates the double-break reset sequence.
module updi_phy_core
    import updi_phy_pkg::*;
#(
    parameter int DOUBLE_BREAK_PULSE_CLK = 250_000,
    parameter int CLKS_PER_BIT           = 100,
    parameter int FIFO_DEPTH             = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] uart_tx_fifo_data,
    input  logic       uart_tx_fifo_wr_en,
    output logic       uart_tx_fifo_full,
    output logic [7:0] uart_rx_fifo_data,
    input  logic       uart_rx_fifo_rd_en,
    output logic       uart_rx_fifo_empty,
    output logic       rx_error,
    input  logic       double_break_start,
    output logic       double_break_busy,
    output logic       double_break_done,
    inout  wire        updi
);

    localparam int BRK_TOTAL = 4 * DOUBLE_BREAK_PULSE_CLK;
    localparam int BRK_CW    = $clog2(BRK_TOTAL);
    localparam int BIT_CW    = $clog2(CLKS_PER_BIT);

    localparam logic [BRK_CW-1:0] BRK_END_LOW1  = BRK_CW'(DOUBLE_BREAK_PULSE_CLK - 1);
    localparam logic [BRK_CW-1:0] BRK_END_HIGH1 = BRK_CW'(2 * DOUBLE_BREAK_PULSE_CLK - 1);
    localparam logic [BRK_CW-1:0] BRK_END_LOW2  = BRK_CW'(3 * DOUBLE_BREAK_PULSE_CLK - 1);
    localparam logic [BRK_CW-1:0] BRK_END_HIGH2 = BRK_CW'(BRK_TOTAL - 1);
    localparam logic [BIT_CW-1:0] BIT_LAST      = BIT_CW'(CLKS_PER_BIT - 1);
    localparam logic [BIT_CW-1:0] BIT_HALF      = BIT_CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [3:0]        FRAME_LAST    = 4'(UART_FRAME_BITS - 1);
    localparam logic [3:0]        RX_LAST       = 4'(UART_RX_BITS - 1);

    phy_state_e                 state_q, state_d;
    brk_phase_e                 phase_q, phase_d;
    logic [BRK_CW-1:0]          brk_cnt_q, brk_cnt_d;
    logic                       done_d;
    logic [UART_FRAME_BITS-1:0] tx_shift_q, tx_shift_d;
    logic [3:0]                 tx_bit_q, tx_bit_d;
    logic [BIT_CW-1:0]          tx_clk_q, tx_clk_d;
    logic                       tx_load;
    logic                       tx_pop;
    logic [7:0]                 tx_head;
    logic                       tx_empty;
    logic                       line_low_q, line_low_d;
    logic                       uart_tx_active;

    rx_state_e                  rx_state_q, rx_state_d;
    logic [BIT_CW-1:0]          rx_clk_q, rx_clk_d;
    logic [3:0]                 rx_cnt_q, rx_cnt_d;
    logic [UART_RX_BITS-1:0]    rx_shift_q, rx_shift_d;
    logic                       rx_push, rx_err_d;
    logic                       rx_full;
    logic                       rx_meta, rx_sync, rx_prev;
    logic                       rx_enable;

    updi_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (uart_tx_fifo_wr_en),
        .wr_data (uart_tx_fifo_data),
        .full    (uart_tx_fifo_full),
        .rd_en   (tx_pop),
        .rd_data (tx_head),
        .empty   (tx_empty)
    );

    updi_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (rx_push && !rx_full),
        .wr_data (rx_shift_d[7:0]),
        .full    (rx_full),
        .rd_en   (uart_rx_fifo_rd_en),
        .rd_data (uart_rx_fifo_data),
        .empty   (uart_rx_fifo_empty)
    );

    assign updi              = line_low_q ? 1'b0 : 1'bz;
    assign double_break_busy = (state_q == ST_BREAK);
    assign uart_tx_active    = (state_q == ST_TX);
    assign rx_enable         = !uart_tx_active && !double_break_busy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q           <= ST_IDLE;
            phase_q           <= BRK_LOW1;
            brk_cnt_q         <= '0;
            double_break_done <= 1'b0;
            tx_shift_q        <= '1;
            tx_bit_q          <= '0;
            tx_clk_q          <= '0;
            line_low_q        <= 1'b0;
        end else begin
            state_q           <= state_d;
            phase_q           <= phase_d;
            brk_cnt_q         <= brk_cnt_d;
            double_break_done <= done_d;
            tx_shift_q        <= tx_shift_d;
            tx_bit_q          <= tx_bit_d;
            tx_clk_q          <= tx_clk_d;
            line_low_q        <= line_low_d;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        brk_cnt_d  = brk_cnt_q;
        done_d     = 1'b0;
        tx_shift_d = tx_shift_q;
        tx_bit_d   = tx_bit_q;
        tx_clk_d   = tx_clk_q;
        tx_load    = 1'b0;
        tx_pop     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (double_break_start) begin
                    state_d   = ST_BREAK;
                    phase_d   = BRK_LOW1;
                    brk_cnt_d = '0;
                end else if (!tx_empty) begin
                    tx_load = 1'b1;
                end
            end
            ST_BREAK: begin
                brk_cnt_d = brk_cnt_q + 1'b1;
                unique case (phase_q)
                    BRK_LOW1:  if (brk_cnt_q == BRK_END_LOW1)  phase_d = BRK_HIGH1;
                    BRK_HIGH1: if (brk_cnt_q == BRK_END_HIGH1) phase_d = BRK_LOW2;
                    BRK_LOW2:  if (brk_cnt_q == BRK_END_LOW2)  phase_d = BRK_HIGH2;
                    BRK_HIGH2: begin
                        if (brk_cnt_q == BRK_END_HIGH2) begin
                            state_d   = ST_IDLE;
                            brk_cnt_d = '0;
                            done_d    = 1'b1;
                        end
                    end
                    default: phase_d = BRK_LOW1;
                endcase
            end
            ST_TX: begin
                if (tx_clk_q == BIT_LAST) begin
                    tx_clk_d = '0;
                    if (tx_bit_q == FRAME_LAST) begin
                        if (!tx_empty) tx_load = 1'b1;
                        else           state_d = ST_IDLE;
                    end else begin
                        tx_bit_d   = tx_bit_q + 1'b1;
                        tx_shift_d = {tx_shift_q[0], tx_shift_q[UART_FRAME_BITS-1:1]};
                    end
                end else begin
                    tx_clk_d = tx_clk_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (tx_load) begin
            state_d    = ST_TX;
            tx_pop     = 1'b1;
            tx_shift_d = build_frame(tx_head);
            tx_bit_d   = '0;
            tx_clk_d   = '0;
        end
    end

    // Line drive is registered from next-state values so it changes on the same edge as the FSM.
    always_comb begin
        line_low_d = ((state_d == ST_BREAK) && ((phase_d == BRK_LOW1) || (phase_d == BRK_LOW2)))
                  || ((state_d == ST_TX) && !tx_shift_d[0]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            rx_prev    <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_clk_q   <= '0;
            rx_cnt_q   <= '0;
            rx_shift_q <= '0;
            rx_error   <= 1'b0;
        end else begin
            rx_meta    <= updi;
            rx_sync    <= rx_meta;
            rx_prev    <= rx_sync;
            rx_state_q <= rx_state_d;
            rx_clk_q   <= rx_clk_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_shift_q <= rx_shift_d;
            rx_error   <= rx_err_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_clk_d   = rx_clk_q;
        rx_cnt_d   = rx_cnt_q;
        rx_shift_d = rx_shift_q;
        rx_push    = 1'b0;
        rx_err_d   = 1'b0;

        // Own echo during TX or break must never reach the RX FIFO.
        if (!rx_enable) begin
            rx_state_d = RX_IDLE;
        end else begin
            unique case (rx_state_q)
                RX_IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        rx_state_d = RX_START;
                        rx_clk_d   = '0;
                    end
                end
                RX_START: begin
                    if (rx_clk_q == BIT_HALF) begin
                        if (rx_sync) begin
                            rx_state_d = RX_IDLE;
                        end else begin
                            rx_state_d = RX_BITS;
                            rx_clk_d   = '0;
                            rx_cnt_d   = '0;
                        end
                    end else begin
                        rx_clk_d = rx_clk_q + 1'b1;
                    end
                end
                RX_BITS: begin
                    if (rx_clk_q == BIT_LAST) begin
                        rx_clk_d             = '0;
                        rx_cnt_d             = rx_cnt_q + 1'b1;
                        rx_shift_d[rx_cnt_q] = rx_sync;
                        if (rx_cnt_q == RX_LAST) begin
                            rx_state_d = RX_IDLE;
                            if (rx_shift_d[UART_RX_BITS-1] && !(^rx_shift_d[UART_DATA_BITS:0]))
                                rx_push = 1'b1;
                            else
                                rx_err_d = 1'b1;
                        end
                    end else begin
                        rx_clk_d = rx_clk_q + 1'b1;
                    end
                end
                default: rx_state_d = RX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_updi_phy_core.sv
// Directed bench for updi_phy_core: double break timing, TX framing, RX good/bad frames,
// TX queueing behind a break, and reset during a break.
module tb_updi_phy_core;

    localparam int PULSE      = 250;
    localparam int CPB        = 4;
    localparam int DEPTH      = 16;
    localparam int BRK_LEN    = 4 * PULSE;
    localparam int FRAME_CLKS = 12 * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] uart_tx_fifo_data = 8'h00;
    logic       uart_tx_fifo_wr_en = 1'b0;
    logic       uart_tx_fifo_full;
    logic [7:0] uart_rx_fifo_data;
    logic       uart_rx_fifo_rd_en = 1'b0;
    logic       uart_rx_fifo_empty;
    logic       rx_error;
    logic       double_break_start = 1'b0;
    logic       double_break_busy;
    logic       double_break_done;
    logic       tb_low = 1'b0;
    wire        updi;

    assign updi = tb_low ? 1'b0 : 1'bz;
    pullup (updi);

    int checks        = 0;
    int failures      = 0;
    int rx_err_pulses = 0;

    updi_phy_core #(
        .DOUBLE_BREAK_PULSE_CLK (PULSE),
        .CLKS_PER_BIT           (CPB),
        .FIFO_DEPTH             (DEPTH)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .uart_tx_fifo_data  (uart_tx_fifo_data),
        .uart_tx_fifo_wr_en (uart_tx_fifo_wr_en),
        .uart_tx_fifo_full  (uart_tx_fifo_full),
        .uart_rx_fifo_data  (uart_rx_fifo_data),
        .uart_rx_fifo_rd_en (uart_rx_fifo_rd_en),
        .uart_rx_fifo_empty (uart_rx_fifo_empty),
        .rx_error           (rx_error),
        .double_break_start (double_break_start),
        .double_break_busy  (double_break_busy),
        .double_break_done  (double_break_done),
        .updi               (updi)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rx_error === 1'b1) rx_err_pulses++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected frame, built bit by bit from the link's frame definition.
    function automatic logic [11:0] exp_frame(input logic [7:0] b);
        logic [11:0] f;
        int ones;
        ones = 0;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            f[i+1] = b[i];
            if (b[i]) ones++;
        end
        f[9]  = (ones % 2 == 1);
        f[10] = 1'b1;
        f[11] = 1'b1;
        return f;
    endfunction

    task automatic run_break(input string tag);
        int line_mism, busy_mism, done_at;
        logic exp_line;
        line_mism = 0;
        busy_mism = 0;
        done_at   = -1;
        double_break_start = 1'b1;
        step();
        double_break_start = 1'b0;
        check({tag, "_low_from_E"}, updi, 1'b0);
        check({tag, "_busy_from_E"}, double_break_busy, 1'b1);
        for (int k = 0; k <= BRK_LEN + 1; k++) begin
            if (k > 0) step();
            exp_line = !((k < PULSE) || (k >= 2 * PULSE && k < 3 * PULSE));
            if (updi !== exp_line) line_mism++;
            if (double_break_busy !== (k < BRK_LEN)) busy_mism++;
            if (double_break_done === 1'b1 && done_at < 0) done_at = k;
            if (k == BRK_LEN + 1) check({tag, "_done_one_cycle"}, double_break_done, 1'b0);
        end
        check({tag, "_line_phase_errors"}, line_mism, 0);
        check({tag, "_busy_errors"}, busy_mism, 0);
        check({tag, "_done_edge"}, done_at, BRK_LEN);
    endtask

    task automatic send_frame(input logic [11:0] bits);
        for (int i = 0; i < 12; i++) begin
            tb_low = !bits[i];
            repeat (CPB) step();
        end
        tb_low = 1'b0;
        repeat (4 * CPB) step();
    endtask

    logic [11:0] obs;
    int          act_mism;
    int          n;

    initial begin
        repeat (2) step();
        check("reset_tx_full", uart_tx_fifo_full, 1'b0);
        check("reset_rx_empty", uart_rx_fifo_empty, 1'b1);
        check("reset_busy", double_break_busy, 1'b0);
        check("reset_line", updi, 1'b1);
        rst = 1'b1;
        repeat (2) step();
        check("reset_rx_error", rx_error, 1'b0);
        check("reset_done", double_break_done, 1'b0);

        // Double break with PULSE=250.
        run_break("brk1");
        check("brk1_rx_empty", uart_rx_fifo_empty, 1'b1);

        // Single TX byte 0x55: 0,1,0,1,0,1,0,1,0,0,1,1.
        uart_tx_fifo_data  = 8'h55;
        uart_tx_fifo_wr_en = 1'b1;
        step();
        uart_tx_fifo_wr_en = 1'b0;
        check("tx55_not_loaded_at_W", dut.uart_tx_active, 1'b0);
        step();
        act_mism = 0;
        for (int k = 0; k < FRAME_CLKS; k++) begin
            if (k % CPB == CPB / 2) obs[k / CPB] = updi;
            if (dut.uart_tx_active !== 1'b1) act_mism++;
            step();
        end
        check("tx55_bits", obs, 12'hCAA);
        check("tx55_active_48", act_mism, 0);
        check("tx55_active_end", dut.uart_tx_active, 1'b0);
        check("tx55_line_released", updi, 1'b1);
        repeat (4) step();
        check("tx55_no_echo", uart_rx_fifo_empty, 1'b1);

        // External good frame 0xA3, parity 0.
        send_frame(12'hD46);
        check("rxA3_not_empty", uart_rx_fifo_empty, 1'b0);
        check("rxA3_data", uart_rx_fifo_data, 8'hA3);
        check("rxA3_no_error", rx_err_pulses, 0);
        uart_rx_fifo_rd_en = 1'b1;
        step();
        uart_rx_fifo_rd_en = 1'b0;
        check("rxA3_empty_after_pop", uart_rx_fifo_empty, 1'b1);

        // Bad parity, then bad first stop bit.
        send_frame(12'hF46);
        check("rx_parity_err_pulse", rx_err_pulses, 1);
        check("rx_parity_dropped", uart_rx_fifo_empty, 1'b1);
        send_frame(12'h946);
        check("rx_stop_err_pulse", rx_err_pulses, 2);
        check("rx_stop_dropped", uart_rx_fifo_empty, 1'b1);

        // 17 writes during a break: 16 accepted, TX waits for done.
        double_break_start = 1'b1;
        step();
        double_break_start = 1'b0;
        uart_tx_fifo_wr_en = 1'b1;
        for (int i = 0; i < 17; i++) begin
            uart_tx_fifo_data = 8'h10 + 8'(i);
            step();
            if (i == 14) check("q_not_full_at_15", uart_tx_fifo_full, 1'b0);
            if (i == 15) check("q_full_at_16", uart_tx_fifo_full, 1'b1);
        end
        uart_tx_fifo_wr_en = 1'b0;
        check("q_full_after_17", uart_tx_fifo_full, 1'b1);
        check("q_no_tx_in_break", dut.uart_tx_active, 1'b0);
        n = 17;
        while (double_break_done !== 1'b1 && n < BRK_LEN + 20) begin
            step();
            n++;
        end
        check("q_break_done_edge", n, BRK_LEN);
        check("q_tx_idle_at_done", dut.uart_tx_active, 1'b0);
        step();
        check("q_tx_starts_after_done", dut.uart_tx_active, 1'b1);
        act_mism = 0;
        for (int f = 0; f < 16; f++) begin
            for (int k = 0; k < FRAME_CLKS; k++) begin
                if (k % CPB == CPB / 2) obs[k / CPB] = updi;
                if (dut.uart_tx_active !== 1'b1) act_mism++;
                step();
            end
            check($sformatf("q_frame%0d", f), obs, exp_frame(8'h10 + 8'(f)));
        end
        check("q_back_to_back", act_mism, 0);
        check("q_tx_done", dut.uart_tx_active, 1'b0);
        check("q_not_full_end", uart_tx_fifo_full, 1'b0);
        repeat (2 * FRAME_CLKS) step();
        check("q_17th_dropped", dut.uart_tx_active, 1'b0);
        check("q_no_echo", uart_rx_fifo_empty, 1'b1);

        // Reset in the middle of a break, then a full sequence.
        double_break_start = 1'b1;
        step();
        double_break_start = 1'b0;
        repeat (100) step();
        check("mid_busy", double_break_busy, 1'b1);
        check("mid_line_low", updi, 1'b0);
        rst = 1'b0;
        #1;
        check("rst_busy_clear", double_break_busy, 1'b0);
        check("rst_line_released", updi, 1'b1);
        check("rst_done_clear", double_break_done, 1'b0);
        step();
        rst = 1'b1;
        step();
        run_break("brk2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/updi_phy_core.md
# updi_phy_core

Physical layer for a single-wire UPDI programming link. Serialises bytes from a TX FIFO onto the open-drain UPDI line, deserialises received frames into an RX FIFO, and generates the UPDI double-break reset sequence. Sits between the UPDI datalink/instruction layer and the bidirectional `updi` pin.

## Interface
- `DOUBLE_BREAK_PULSE_CLK`, default 250_000: length in clocks of each of the four double-break phases.
- `CLKS_PER_BIT`, default 100: UART bit period in clocks (≥ 4).
- `FIFO_DEPTH`, default 16: entries per FIFO (power of two).

- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `uart_tx_fifo_data` in 8: byte to transmit.
- `uart_tx_fifo_wr_en` in 1: push byte; ignored when full.
- `uart_tx_fifo_full` out 1: TX FIFO full.
- `uart_rx_fifo_data` out 8: head of RX FIFO (first-word fall-through).
- `uart_rx_fifo_rd_en` in 1: pop RX head; ignored when empty.
- `uart_rx_fifo_empty` out 1: RX FIFO empty.
- `rx_error` out 1: one-cycle pulse on parity or stop-bit error.
- `double_break_start` in 1: request double break.
- `double_break_busy` out 1: double break in progress.
- `double_break_done` out 1: one-cycle pulse at completion.
- `updi` inout 1: open-drain line; drive `0` or release `z`. Never drives `1`.

## Operation
- Frame: 1 start (0), 8 data LSB-first, even parity, 2 stop (1); 12 bits total; idle = released.
- Top FSM: IDLE, BREAK, TX. RX runs only in IDLE.
- IDLE → BREAK: `double_break_start` high while not TX. Ignored when busy or TX.
- BREAK phases: LOW1, HIGH1, LOW2, HIGH2, each `DOUBLE_BREAK_PULSE_CLK` clocks. LOW drives 0, HIGH releases.
- `double_break_busy` high for the whole sequence.
- On exit, `double_break_done` pulses for one cycle and the FSM returns to IDLE.
- Double break flushes neither FIFO.
- IDLE → TX: TX FIFO non-empty and no break pending. Break start has priority on the same edge.
- TX pops one byte and shifts out the frame. Internal `uart_tx_active` is high from the load edge to the end of the last stop bit.
- TX returns to IDLE, or loads the next byte back-to-back if the FIFO is non-empty.
- RX: 2-FF synchroniser on `updi`. A falling edge in IDLE starts reception.
- RX samples at mid-bit (`CLKS_PER_BIT/2`); the start bit is re-checked at mid-bit and aborted if high.
- RX: good frame → push to RX FIFO. Parity or first-stop error → `rx_error` pulse, byte dropped. RX FIFO full → byte dropped, no error.
- RX ignores the line during TX and BREAK, so own echo is not captured.

## Timing
- Reset: FIFOs empty, `uart_tx_fifo_full`=0, `uart_rx_fifo_empty`=1, `rx_error`=0, `double_break_busy`=0, `double_break_done`=0, `updi`=z, FSM IDLE.
- `double_break_start` sampled at edge E: busy=1 after E, and `updi` is low from E.
- `double_break_done`=1 after edge E+4·`DOUBLE_BREAK_PULSE_CLK` for exactly one cycle; busy falls on the same edge.
- Example: with PULSE=250, done rises after the 1000th edge following E.
- TX write at edge W (FIFO previously empty, IDLE): load and start bit at W+1.
- TX frame lasts 12·`CLKS_PER_BIT` clocks; `uart_tx_active` falls at W+1+12·`CLKS_PER_BIT`.
- FIFO `full`/`empty` flags update on the edge after the push or pop.
- Simultaneous push and pop is legal: count unchanged, even when full.
- Reset mid-frame or mid-break: immediate abort, line released.

## Structure
- Package `updi_phy_pkg`:
  - FSM state enum (IDLE, BREAK, TX);
  - break phase enum;
  - constants `UART_FRAME_BITS=12`, `UART_STOP_BITS=2`.
- Counter widths derived with `$clog2` of `4·DOUBLE_BREAK_PULSE_CLK` and `CLKS_PER_BIT`.
- Sub-module `updi_fifo`: parameterised synchronous FIFO, instantiated twice for TX and RX.

## Test plan
- Reset, then pulse start with PULSE=250: done after exactly 1000 edges; `updi` low for 250, z for 250, low for 250, z for 250.
- Write 0x55, CLKS_PER_BIT=4: `updi` bits 0,1,0,1,0,1,0,1,0,0,1,1 (parity 0); active for 48 clocks; RX FIFO stays empty.
- Drive an external frame for 0xA3 with parity 0: RX FIFO non-empty, data=0xA3. After `rd_en`: empty.
- External frame with bad parity, and one with stop=0: `rx_error` pulses once each; FIFO stays empty.
- Write 17 bytes into the TX FIFO during a break (FIFO_DEPTH=16): full after 16, 17th dropped; TX starts only after done; 16 frames back-to-back.
- Assert `rst` mid-break: busy=0, `updi`=z immediately; the next start yields a full 4·PULSE sequence.
